// File: rtl/obb_sat_engine.sv
`default_nettype none
// ============================================================================
//  Module   : obb_sat_engine
//  Purpose  : Iterative separating-axis test for two oriented bounding boxes.
//             Candidate axes uA, vA, uB, vB are evaluated one per cycle on a
//             single projection datapath; the axis with the smallest
//             (most negative) penetration is reported.
//  Ports    : clk, reset (async, active-high)
//             in_valid / in_ready      : request handshake
//             a_*/b_* pos, u, half     : box centres, unit u-axes, half-extents
//                                        (signed fixed point, FRAC_BITS frac)
//             out_valid / out_ready    : result handshake
//             is_collision, min_pen, min_axis, normal_neg : registered result
//  Revision : 1.0 - initial release
// ============================================================================
module obb_sat_engine #(
    parameter int  INT_BITS   = 8,
    parameter int  FRAC_BITS  = 24,
    parameter int  EARLY_EXIT = 0,
    localparam int W          = INT_BITS + FRAC_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] a_pos_x,
    input  logic signed [W-1:0] a_pos_y,
    input  logic signed [W-1:0] b_pos_x,
    input  logic signed [W-1:0] b_pos_y,
    input  logic signed [W-1:0] a_u_x,
    input  logic signed [W-1:0] a_u_y,
    input  logic signed [W-1:0] b_u_x,
    input  logic signed [W-1:0] b_u_y,
    input  logic signed [W-1:0] a_half_w,
    input  logic signed [W-1:0] a_half_h,
    input  logic signed [W-1:0] b_half_w,
    input  logic signed [W-1:0] b_half_h,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                is_collision,
    output logic signed [W-1:0] min_pen,
    output logic        [1:0]   min_axis,
    output logic                normal_neg
);

    // Working width for all sums: three guard bits above W.
    localparam int XW = W + 3;
    localparam logic signed [XW-1:0] c_pen_max   = {4'b0000, {(W-1){1'b1}}};
    localparam logic signed [XW-1:0] c_pen_min   = {4'b1111, {(W-1){1'b0}}};
    localparam logic signed [W-1:0]  c_best_init = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AXIS = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Captured request
    logic signed [W-1:0] r_a_pos_x, r_a_pos_y, r_b_pos_x, r_b_pos_y;
    logic signed [W-1:0] r_a_u_x, r_a_u_y, r_b_u_x, r_b_u_y;
    logic signed [W-1:0] r_a_half_w, r_a_half_h, r_b_half_w, r_b_half_h;

    logic        [1:0]   r_k;
    logic signed [W-1:0] r_best_pen;
    logic        [1:0]   r_best_axis;
    logic                r_best_neg;

    logic signed [W-1:0] r_min_pen;
    logic        [1:0]   r_min_axis;
    logic                r_normal_neg;
    logic                r_is_collision;

    // ------------------------------------------------------------------
    // Fixed-point helpers
    // ------------------------------------------------------------------
    function automatic logic signed [XW-1:0] sx(input logic signed [W-1:0] x);
        return {{3{x[W-1]}}, x};
    endfunction

    // Full-precision product, arithmetic shift (floor) back to the Q format.
    function automatic logic signed [XW-1:0] fx_mul(input logic signed [XW-1:0] x,
                                                    input logic signed [XW-1:0] y);
        logic signed [2*XW-1:0] p;
        p = (2*XW)'(x) * (2*XW)'(y);
        return XW'(p >>> FRAC_BITS);
    endfunction

    function automatic logic signed [XW-1:0] mag(input logic signed [XW-1:0] x);
        return x[XW-1] ? -x : x;
    endfunction

    // ------------------------------------------------------------------
    // Shared projection datapath for axis r_k
    // ------------------------------------------------------------------
    logic signed [XW-1:0] w_ax, w_ay;
    logic signed [XW-1:0] w_dx, w_dy, w_dp;
    logic signed [XW-1:0] w_ua, w_va, w_ub, w_vb;
    logic signed [XW-1:0] w_ra, w_rb, w_pen;
    logic signed [W-1:0]  w_pen_sat;
    logic                 w_better;
    logic                 w_last;
    logic                 w_accept;
    logic signed [W-1:0]  w_fin_pen;
    logic        [1:0]    w_fin_axis;
    logic                 w_fin_neg;

    // v-axis of a box is its u-axis rotated by +90 degrees: (-u_y, u_x).
    always_comb begin
        w_ax = sx(r_a_u_x);
        w_ay = sx(r_a_u_y);
        case (r_k)
            2'd0: begin w_ax =  sx(r_a_u_x); w_ay = sx(r_a_u_y); end
            2'd1: begin w_ax = -sx(r_a_u_y); w_ay = sx(r_a_u_x); end
            2'd2: begin w_ax =  sx(r_b_u_x); w_ay = sx(r_b_u_y); end
            default: begin w_ax = -sx(r_b_u_y); w_ay = sx(r_b_u_x); end
        endcase
    end

    assign w_dx = sx(r_b_pos_x) - sx(r_a_pos_x);
    assign w_dy = sx(r_b_pos_y) - sx(r_a_pos_y);
    assign w_dp = fx_mul(w_dx, w_ax) + fx_mul(w_dy, w_ay);

    assign w_ua = fx_mul( sx(r_a_u_x), w_ax) + fx_mul(sx(r_a_u_y), w_ay);
    assign w_va = fx_mul(-sx(r_a_u_y), w_ax) + fx_mul(sx(r_a_u_x), w_ay);
    assign w_ub = fx_mul( sx(r_b_u_x), w_ax) + fx_mul(sx(r_b_u_y), w_ay);
    assign w_vb = fx_mul(-sx(r_b_u_y), w_ax) + fx_mul(sx(r_b_u_x), w_ay);

    assign w_ra = fx_mul(sx(r_a_half_w), mag(w_ua)) + fx_mul(sx(r_a_half_h), mag(w_va));
    assign w_rb = fx_mul(sx(r_b_half_w), mag(w_ub)) + fx_mul(sx(r_b_half_h), mag(w_vb));
    assign w_pen = w_ra + w_rb - mag(w_dp);

    always_comb begin
        if (w_pen > c_pen_max) begin
            w_pen_sat = c_pen_max[W-1:0];
        end else if (w_pen < c_pen_min) begin
            w_pen_sat = c_pen_min[W-1:0];
        end else begin
            w_pen_sat = w_pen[W-1:0];
        end
    end

    // Strict compare: on a tie the earlier (lower index) axis is kept.
    assign w_better = (w_pen_sat < r_best_pen);
    // A negative penetration can only follow non-negative ones when early
    // exit is enabled, so the exiting axis is always the current minimum.
    assign w_last   = (r_k == 2'd3) || ((EARLY_EXIT != 0) && w_pen_sat[W-1]);
    assign w_accept = (r_state == S_IDLE) && in_valid;

    assign w_fin_pen  = w_better ? w_pen_sat  : r_best_pen;
    assign w_fin_axis = w_better ? r_k        : r_best_axis;
    assign w_fin_neg  = w_better ? w_dp[XW-1] : r_best_neg;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = ~reset;
                if (in_valid) begin
                    w_state_nxt = S_AXIS;
                end
            end
            S_AXIS: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, best tracking and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_pos_x      <= '0;
            r_a_pos_y      <= '0;
            r_b_pos_x      <= '0;
            r_b_pos_y      <= '0;
            r_a_u_x        <= '0;
            r_a_u_y        <= '0;
            r_b_u_x        <= '0;
            r_b_u_y        <= '0;
            r_a_half_w     <= '0;
            r_a_half_h     <= '0;
            r_b_half_w     <= '0;
            r_b_half_h     <= '0;
            r_k            <= 2'd0;
            r_best_pen     <= c_best_init;
            r_best_axis    <= 2'd0;
            r_best_neg     <= 1'b0;
            r_min_pen      <= '0;
            r_min_axis     <= 2'd0;
            r_normal_neg   <= 1'b0;
            r_is_collision <= 1'b0;
        end else if (w_accept) begin
            r_a_pos_x   <= a_pos_x;
            r_a_pos_y   <= a_pos_y;
            r_b_pos_x   <= b_pos_x;
            r_b_pos_y   <= b_pos_y;
            r_a_u_x     <= a_u_x;
            r_a_u_y     <= a_u_y;
            r_b_u_x     <= b_u_x;
            r_b_u_y     <= b_u_y;
            r_a_half_w  <= a_half_w;
            r_a_half_h  <= a_half_h;
            r_b_half_w  <= b_half_w;
            r_b_half_h  <= b_half_h;
            r_k         <= 2'd0;
            r_best_pen  <= c_best_init;
            r_best_axis <= 2'd0;
            r_best_neg  <= 1'b0;
        end else if (r_state == S_AXIS) begin
            r_k <= r_k + 2'd1;
            if (w_better) begin
                r_best_pen  <= w_pen_sat;
                r_best_axis <= r_k;
                r_best_neg  <= w_dp[XW-1];
            end
            // Result registers only move when a new result is complete, so
            // they stay stable through DONE regardless of out_ready.
            if (w_last) begin
                r_min_pen      <= w_fin_pen;
                r_min_axis     <= w_fin_axis;
                r_normal_neg   <= w_fin_neg;
                r_is_collision <= ~w_fin_pen[W-1];
            end
        end
    end

    assign min_pen      = r_min_pen;
    assign min_axis     = r_min_axis;
    assign normal_neg   = r_normal_neg;
    assign is_collision = r_is_collision;

endmodule
`default_nettype wire

// File: tb/tb_obb_sat_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obb_sat_engine
//  Purpose  : Scoreboard bench for obb_sat_engine. Two instances (early exit
//             off / on) share stimulus; a behavioural separating-axis model
//             supplies expected results, a monitor compares on out_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_obb_sat_engine;

    localparam int FRAC = 24;
    localparam logic signed [31:0] ONE = 32'sh0100_0000;

    typedef logic signed [127:0] big_t;

    typedef struct {
        logic signed [31:0] apx, apy, bpx, bpy;
        logic signed [31:0] aux, auy, bux, buy;
        logic signed [31:0] ahw, ahh, bhw, bhh;
    } box_t;

    typedef struct {
        logic [31:0] pen;
        logic [1:0]  axis;
        logic        neg;
        logic        coll;
        int          lat;
        int          acc;
    } exp_t;

    logic clk;
    logic reset;
    logic in_valid;
    logic out_ready;
    logic signed [31:0] a_pos_x, a_pos_y, b_pos_x, b_pos_y;
    logic signed [31:0] a_u_x, a_u_y, b_u_x, b_u_y;
    logic signed [31:0] a_half_w, a_half_h, b_half_w, b_half_h;

    logic        in_ready     [2];
    logic        out_valid    [2];
    logic        is_collision [2];
    logic [31:0] min_pen      [2];
    logic [1:0]  min_axis     [2];
    logic        normal_neg   [2];

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    obb_sat_engine #(.INT_BITS(8), .FRAC_BITS(24), .EARLY_EXIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
        .a_pos_x(a_pos_x), .a_pos_y(a_pos_y), .b_pos_x(b_pos_x), .b_pos_y(b_pos_y),
        .a_u_x(a_u_x), .a_u_y(a_u_y), .b_u_x(b_u_x), .b_u_y(b_u_y),
        .a_half_w(a_half_w), .a_half_h(a_half_h), .b_half_w(b_half_w), .b_half_h(b_half_h),
        .out_valid(out_valid[0]), .out_ready(out_ready), .is_collision(is_collision[0]),
        .min_pen(min_pen[0]), .min_axis(min_axis[0]), .normal_neg(normal_neg[0])
    );

    obb_sat_engine #(.INT_BITS(8), .FRAC_BITS(24), .EARLY_EXIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
        .a_pos_x(a_pos_x), .a_pos_y(a_pos_y), .b_pos_x(b_pos_x), .b_pos_y(b_pos_y),
        .a_u_x(a_u_x), .a_u_y(a_u_y), .b_u_x(b_u_x), .b_u_y(b_u_y),
        .a_half_w(a_half_w), .a_half_h(a_half_h), .b_half_w(b_half_w), .b_half_h(b_half_h),
        .out_valid(out_valid[1]), .out_ready(out_ready), .is_collision(is_collision[1]),
        .min_pen(min_pen[1]), .min_axis(min_axis[1]), .normal_neg(normal_neg[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Reference model: separating-axis test in wide plain arithmetic
    // ------------------------------------------------------------------
    function automatic big_t fx(input big_t a, input big_t b);
        big_t p;
        p = a * b;
        return p >>> FRAC;
    endfunction

    function automatic big_t babs(input big_t a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic big_t radius(input big_t ux, input big_t uy, input big_t hw,
                                    input big_t hh, input big_t ax, input big_t ay);
        return fx(hw, babs(fx(ux, ax) + fx(uy, ay))) + fx(hh, babs(fx(-uy, ax) + fx(ux, ay)));
    endfunction

    function automatic exp_t model(input box_t b, input bit early);
        big_t axx[4];
        big_t axy[4];
        big_t aux, auy, bux, buy, dx, dy, dp, pen, best;
        exp_t e;
        aux = b.aux; auy = b.auy; bux = b.bux; buy = b.buy;
        axx[0] = aux;  axy[0] = auy;
        axx[1] = -auy; axy[1] = aux;
        axx[2] = bux;  axy[2] = buy;
        axx[3] = -buy; axy[3] = bux;
        dx = big_t'(b.bpx) - big_t'(b.apx);
        dy = big_t'(b.bpy) - big_t'(b.apy);
        best   = 128'sd2147483647;
        e.axis = 2'd0;
        e.neg  = 1'b0;
        e.lat  = 4;
        e.acc  = 0;
        for (int k = 0; k < 4; k++) begin
            dp  = fx(dx, axx[k]) + fx(dy, axy[k]);
            pen = radius(aux, auy, big_t'(b.ahw), big_t'(b.ahh), axx[k], axy[k])
                + radius(bux, buy, big_t'(b.bhw), big_t'(b.bhh), axx[k], axy[k])
                - babs(dp);
            if (pen > 128'sd2147483647)  pen = 128'sd2147483647;
            if (pen < -128'sd2147483648) pen = -128'sd2147483648;
            if (pen < best) begin
                best   = pen;
                e.axis = 2'(k);
                e.neg  = (dp < 0);
            end
            if (early && pen < 0) begin
                e.lat = k + 1;
                break;
            end
        end
        e.pen  = best[31:0];
        e.coll = (best >= 0);
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic box_t mk_box(input logic signed [31:0] apx, input logic signed [31:0] bpx,
                                    input logic signed [31:0] bux, input logic signed [31:0] buy);
        box_t b;
        b.apx = apx; b.apy = 32'sd0; b.bpx = bpx; b.bpy = 32'sd0;
        b.aux = ONE; b.auy = 32'sd0; b.bux = bux; b.buy = buy;
        b.ahw = ONE; b.ahh = ONE; b.bhw = ONE; b.bhh = ONE;
        return b;
    endfunction

    function automatic logic signed [31:0] rnd_pos();
        return $signed($urandom_range(0, 32'h0800_0000)) - 32'sh0400_0000;
    endfunction

    function automatic logic signed [31:0] rnd_half();
        return $signed($urandom_range(32'h0040_0000, 32'h0200_0000));
    endfunction

    function automatic box_t rand_box();
        box_t b;
        real th;
        b.apx = rnd_pos(); b.apy = rnd_pos(); b.bpx = rnd_pos(); b.bpy = rnd_pos();
        th = real'($urandom_range(0, 3599)) * 3.14159265358979 / 1800.0;
        b.aux = $rtoi($cos(th) * 16777216.0);
        b.auy = $rtoi($sin(th) * 16777216.0);
        th = real'($urandom_range(0, 3599)) * 3.14159265358979 / 1800.0;
        b.bux = $rtoi($cos(th) * 16777216.0);
        b.buy = $rtoi($sin(th) * 16777216.0);
        b.ahw = rnd_half(); b.ahh = rnd_half(); b.bhw = rnd_half(); b.bhh = rnd_half();
        return b;
    endfunction

    task automatic drive(input box_t b);
        a_pos_x = b.apx; a_pos_y = b.apy; b_pos_x = b.bpx; b_pos_y = b.bpy;
        a_u_x = b.aux; a_u_y = b.auy; b_u_x = b.bux; b_u_y = b.buy;
        a_half_w = b.ahw; a_half_h = b.ahh; b_half_w = b.bhw; b_half_h = b.bhh;
    endtask

    // Issue one request to both engines; returns just after the accept edge.
    task automatic issue(input box_t b, input bit use_k, input logic [31:0] kpen,
                         input logic [1:0] kax, input logic kcoll,
                         input int klat0, input int klat1);
        exp_t e0, e1;
        int waited;
        waited = 0;
        @(negedge clk);
        while (!(in_ready[0] && in_ready[1]) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            $display("FAIL accept_timeout: in_ready=%0d/%0d, required 1/1", in_ready[0], in_ready[1]);
            $fatal(1);
        end
        drive(b);
        in_valid = 1'b1;
        e0 = model(b, 1'b0);
        e1 = model(b, 1'b1);
        if (use_k) begin
            e0.pen = kpen; e0.axis = kax; e0.neg = 1'b0; e0.coll = kcoll; e0.lat = klat0;
            e1.pen = kpen; e1.axis = kax; e1.neg = 1'b0; e1.coll = kcoll; e1.lat = klat1;
        end
        e0.acc = cyc + 1;
        e1.acc = cyc + 1;
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while ((q0.size() != 0 || q1.size() != 0) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            $display("FAIL drain_timeout: %0d/%0d results outstanding, required 0/0", q0.size(), q1.size());
            $fatal(1);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard (all comparisons happen here)
    // ------------------------------------------------------------------
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    logic seen [2] = '{1'b0, 1'b0};
    logic rchk [2] = '{1'b0, 1'b0};
    logic rel_chk = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   have;
        if (reset) begin
            q0.delete();
            q1.delete();
            for (int i = 0; i < 2; i++) begin
                seen[i] = 1'b0;
                rchk[i] = 1'b0;
                check($sformatf("rst_in_ready dut%0d", i),     64'(in_ready[i]),     64'd0);
                check($sformatf("rst_out_valid dut%0d", i),    64'(out_valid[i]),    64'd0);
                check($sformatf("rst_is_collision dut%0d", i), 64'(is_collision[i]), 64'd0);
                check($sformatf("rst_min_pen dut%0d", i),      64'(min_pen[i]),      64'd0);
                check($sformatf("rst_min_axis dut%0d", i),     64'(min_axis[i]),     64'd0);
                check($sformatf("rst_normal_neg dut%0d", i),   64'(normal_neg[i]),   64'd0);
            end
            rel_chk = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rel_chk) check($sformatf("in_ready_after_reset dut%0d", i), 64'(in_ready[i]), 64'd1);
                if (rchk[i]) begin
                    check($sformatf("in_ready_after_handshake dut%0d", i), 64'(in_ready[i]), 64'd1);
                    rchk[i] = 1'b0;
                end
                if (out_valid[i]) begin
                    check($sformatf("in_ready_while_done dut%0d", i), 64'(in_ready[i]), 64'd0);
                    have = (i == 0) ? (q0.size() != 0) : (q1.size() != 0);
                    if (!have) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result dut%0d: out_valid=1, required 0 (no request outstanding)", i);
                    end else begin
                        if (i == 0) e = q0[0];
                        else        e = q1[0];
                        if (!seen[i]) begin
                            seen[i] = 1'b1;
                            check($sformatf("latency dut%0d", i), 64'(cyc - e.acc), 64'(e.lat));
                        end
                        check($sformatf("min_pen dut%0d", i),      64'(min_pen[i]),      64'(e.pen));
                        check($sformatf("min_axis dut%0d", i),     64'(min_axis[i]),     64'(e.axis));
                        check($sformatf("normal_neg dut%0d", i),   64'(normal_neg[i]),   64'(e.neg));
                        check($sformatf("is_collision dut%0d", i), 64'(is_collision[i]), 64'(e.coll));
                        if (out_ready) begin
                            if (i == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                            seen[i] = 1'b0;
                            rchk[i] = 1'b1;
                        end
                    end
                end
            end
            rel_chk = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    initial begin
        box_t  b;
        int    waited;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(mk_box(32'sd0, 32'sd0, ONE, 32'sd0));
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Axis-aligned touch
        issue(mk_box(32'sd0, 32'sh0180_0000, ONE, 32'sd0), 1'b1, 32'h0080_0000, 2'd0, 1'b1, 4, 4);
        // Separated with uA/uB tie; early exit reports axis 0 after one cycle
        issue(mk_box(32'sd0, 32'sh0300_0000, ONE, 32'sd0), 1'b1, 32'hFF00_0000, 2'd0, 1'b0, 4, 1);
        // Rotated B and its mirror image
        issue(mk_box(32'sd0,  32'sh0233_3333, 32'sh00B5_04F3, 32'sh00B5_04F3), 1'b0, '0, '0, 1'b0, 0, 0);
        issue(mk_box(32'sd0, -32'sh0233_3333, 32'sh00B5_04F3, 32'sh00B5_04F3), 1'b0, '0, '0, 1'b0, 0, 0);
        // Saturation of a hugely negative penetration
        issue(mk_box(32'sh8100_0000, 32'sh7F00_0000, ONE, 32'sd0), 1'b1, 32'h8000_0000, 2'd0, 1'b0, 4, 1);

        // Randomised pairs
        for (int n = 0; n < 40; n++) begin
            issue(rand_box(), 1'b0, '0, '0, 1'b0, 0, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Backpressure: result held for 10+ cycles, new requests ignored
        wait_drain();
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(rand_box(), 1'b0, '0, '0, 1'b0, 0, 0);
        waited = 0;
        while (!(out_valid[0] && out_valid[1]) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            $display("FAIL result_timeout: out_valid=%0d/%0d, required 1/1", out_valid[0], out_valid[1]);
            $fatal(1);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            b = rand_box();
            drive(b);
            in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Reset while the third axis is being evaluated
        issue(mk_box(32'sd0, 32'sh0180_0000, ONE, 32'sd0), 1'b1, 32'h0080_0000, 2'd0, 1'b1, 4, 4);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        issue(mk_box(32'sd0, 32'sh0300_0000, ONE, 32'sd0), 1'b1, 32'hFF00_0000, 2'd0, 1'b0, 4, 1);
        issue(rand_box(), 1'b0, '0, '0, 1'b0, 0, 0);
        wait_drain();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
